// File: rtl/dekatron_decade_counter_if.sv
// Handshake and data bundle for the dekatron decade counter.
// The master drives commands; the slave (counter) returns value and status.
interface dekatron_decade_counter_if #(
    parameter int DIGITS = 3
) ();
    logic                  Request;
    logic                  Dec;
    logic                  Set;
    logic                  Clear;
    logic [4*DIGITS-1:0]   In;
    logic                  Ready;
    logic [4*DIGITS-1:0]   Out;
    logic [10*DIGITS-1:0]  PosOut;
    logic                  Zero;
    logic                  Overflow;
    logic                  Err;

    modport master (
        output Request, Dec, Set, Clear, In,
        input  Ready, Out, PosOut, Zero, Overflow, Err
    );

    modport slave (
        input  Request, Dec, Set, Clear, In,
        output Ready, Out, PosOut, Zero, Overflow, Err
    );
endinterface

// File: rtl/dekatron_decade_counter.sv
// Multi-digit decimal up/down counter built from one-hot ten-position rings.
// Carries and borrows ripple one digit per clock, like a dekatron tube chain.
module dekatron_decade_counter #(
    parameter int DIGITS = 3
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    dekatron_decade_counter_if.slave   bus
);
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        S_IDLE,
        S_RIPPLE
    } state_t;

    state_t                   r_state, w_state;
    logic [PW-1:0]            r_ptr, w_ptr;
    logic                     r_dir, w_dir;
    logic [DIGITS-1:0][9:0]   r_pos, w_pos;
    logic                     r_ovf, w_ovf;
    logic                     r_err, w_err;
    logic [DIGITS-1:0][3:0]   w_bcd;
    logic                     w_zero;

    // dn=1 rotates toward lower positions (decrement)
    function automatic logic [9:0] f_step(input logic [9:0] d, input logic dn);
        return dn ? {d[0], d[9:1]} : {d[8:0], d[9]};
    endfunction

    function automatic logic f_wrap(input logic [9:0] d, input logic dn);
        return dn ? d[0] : d[9];
    endfunction

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_dir   = r_dir;
        w_pos   = r_pos;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        if (bus.Clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_pos[i] = 10'd1;
            end
            w_state = S_IDLE;
            w_ptr   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.Set) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (bus.In[4*i +: 4] > 4'd9) begin
                                w_pos[i] = 10'd1;
                                w_err    = 1'b1;
                            end else begin
                                w_pos[i] = 10'd1 << bus.In[4*i +: 4];
                            end
                        end
                    end else if (bus.Request) begin
                        w_pos[0] = f_step(r_pos[0], bus.Dec);
                        w_dir    = bus.Dec;
                        if (f_wrap(r_pos[0], bus.Dec)) begin
                            if (DIGITS > 1) begin
                                w_state = S_RIPPLE;
                                w_ptr   = PW'(1);
                            end else begin
                                w_ovf = 1'b1;
                            end
                        end
                    end
                end
                S_RIPPLE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (PW'(i) == r_ptr) begin
                            w_pos[i] = f_step(r_pos[i], r_dir);
                            if (f_wrap(r_pos[i], r_dir) && i < DIGITS - 1) begin
                                w_ptr = PW'(i + 1);
                            end else begin
                                w_state = S_IDLE;
                                w_ptr   = '0;
                                w_ovf   = f_wrap(r_pos[i], r_dir) && (i == DIGITS - 1);
                            end
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_ptr   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_dir   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_pos[i] <= 10'd1;
            end
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_dir   <= w_dir;
            r_pos   <= w_pos;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_bcd  = '0;
        w_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (r_pos[i][k]) begin
                    w_bcd[i] = w_bcd[i] | 4'(k);
                end
            end
            w_zero = w_zero & r_pos[i][0];
        end
    end

    assign bus.Ready    = (r_state == S_IDLE);
    assign bus.Out      = w_bcd;
    assign bus.PosOut   = r_pos;
    assign bus.Zero     = w_zero;
    assign bus.Overflow = r_ovf;
    assign bus.Err      = r_err;
endmodule
